wb_regfile: RTL and testbench

Write-back stage and architectural register file of the 5-stage RISC-V pipeline. Consumes the IW-stage outputs of the memory/write-back pipeline register, selects the write-back result, and commits it to a 32 x 32-bit register file. Also serves the decode stage's two combinational read ports, with same-cycle write-to-read bypass so no separate half-cycle write convention is needed.

---
 rtl/wb_regfile_pkg.sv | 13 +
 rtl/regfile_2r1w.sv | 63 ++++++
 rtl/wb_regfile.sv | 58 +++++
 tb/tb_wb_regfile.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared pipeline constants: data width, register-index width and the
// write-back result-select encodings.
package wb_regfile_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = $clog2(NREGS);

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

endpackage

// File: rtl/regfile_2r1w.sv
// 32 x XLEN register file: one synchronous write port, two combinational
// read ports with same-cycle write bypass, and an unbypassed debug port.
// Index 0 reads as zero on every port and is never written.
module regfile_2r1w
    import wb_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [XLEN-1:0]   dbg_data
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    // Next array contents: reset clears everything and wins over a write;
    // entry 0 is held at zero regardless.
    always_comb begin
        regs_d = regs_q;
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_d[i] = '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
        regs_d[0] = '0;
    end

    // Array register.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    // Read ports: x0 forced to zero, otherwise the in-flight write is bypassed
    // so decode sees the value being committed this cycle.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != '0) begin
            rdata1 = (we && (waddr == raddr1)) ? wdata : regs_q[raddr1];
        end
        if (raddr2 != '0) begin
            rdata2 = (we && (waddr == raddr2)) ? wdata : regs_q[raddr2];
        end
    end

    // Debug port shows committed state only.
    always_comb begin
        dbg_data = '0;
        if (dbg_addr != '0) begin
            dbg_data = regs_q[dbg_addr];
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the result from the IW-stage inputs, qualifies
// the write and commits it to the architectural register file, which also
// serves the decode read ports.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   ALUResultW,
    input  logic [XLEN-1:0]   ReadDataW,
    input  logic [XLEN-1:0]   PCPlus4W,
    input  logic [REG_AW-1:0] rdW,
    input  logic              RegWriteW,
    input  logic [1:0]        ResultSrcW,
    output logic [XLEN-1:0]   ResultW,
    input  logic [REG_AW-1:0] rs1D,
    input  logic [REG_AW-1:0] rs2D,
    output logic [XLEN-1:0]   RD1D,
    output logic [XLEN-1:0]   RD2D,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [XLEN-1:0]   dbg_data
);

    logic we;

    // Result select; the reserved encoding yields zero, which is then
    // committed like any other result.
    always_comb begin
        ResultW = '0;
        case (ResultSrcW)
            RESULT_ALU: ResultW = ALUResultW;
            RESULT_MEM: ResultW = ReadDataW;
            RESULT_PC4: ResultW = PCPlus4W;
            default:    ResultW = '0;
        endcase
    end

    // Writes to x0 and writes during reset are dropped, which also disables
    // the read bypass for them.
    always_comb begin
        we = RegWriteW && (rdW != '0) && !reset;
    end

    regfile_2r1w u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .waddr    (rdW),
        .wdata    (ResultW),
        .raddr1   (rs1D),
        .raddr2   (rs2D),
        .rdata1   (RD1D),
        .rdata2   (RD2D),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a cycle-by-cycle vector table with
// hand-computed expectations plus a few hand-written sequences.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic [4:0]  rdW;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ResultW;
    logic [4:0]  rs1D;
    logic [4:0]  rs2D;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_tests;
    int n_fail;

    wb_regfile dut (
        .clk        (clk),
        .reset      (reset),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PCPlus4W   (PCPlus4W),
        .rdW        (rdW),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .ResultW    (ResultW),
        .rs1D       (rs1D),
        .rs2D       (rs2D),
        .RD1D       (RD1D),
        .RD2D       (RD2D),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        wr;
        logic [4:0]  rd;
        logic [1:0]  src;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  dbg;
        logic [31:0] exp_res;
        logic [31:0] exp_rd1;
        logic [31:0] exp_rd2;
        logic [31:0] exp_dbg;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(logic rst, logic wr, logic [4:0] rd, logic [1:0] src,
                                logic [31:0] alu, logic [31:0] mem, logic [31:0] pc4,
                                logic [4:0] rs1, logic [4:0] rs2, logic [4:0] dbg,
                                logic [31:0] er, logic [31:0] e1, logic [31:0] e2,
                                logic [31:0] ed);
        vec_t v;
        v.rst = rst; v.wr = wr; v.rd = rd; v.src = src;
        v.alu = alu; v.mem = mem; v.pc4 = pc4;
        v.rs1 = rs1; v.rs2 = rs2; v.dbg = dbg;
        v.exp_res = er; v.exp_rd1 = e1; v.exp_rd2 = e2; v.exp_dbg = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic wr, input logic [4:0] rd,
                         input logic [1:0] src, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [31:0] pc4,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] dbg);
        reset = rst; RegWriteW = wr; rdW = rd; ResultSrcW = src;
        ALUResultW = alu; ReadDataW = mem; PCPlus4W = pc4;
        rs1D = rs1; rs2D = rs2; dbg_addr = dbg;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic dbg_sweep(input string name, input logic [31:0] base, input logic zero);
        logic [31:0] exp;
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            exp = (zero || i == 0) ? 32'h0 : base ^ 32'(i);
            check($sformatf("%s[%0d]", name, i), dbg_data, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle();

        // Reset, then every entry reads zero.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle();
        dbg_sweep("rst_dbg", 32'h0, 1'b1);
        rs1D = 5'd5; rs2D = 5'd31;
        #1;
        check("rst_rd1", RD1D, 32'h0);
        check("rst_rd2", RD2D, 32'h0);

        //           rst  wr   rd    src    alu           mem           pc4           rs1   rs2   dbg     ResultW       RD1D          RD2D          dbg_data
        vecs[0]  = mk(0, 1, 5'd3,  2'b00, 32'hDEADBEEF, 32'h0,        32'h0,        5'd3,  5'd5,  5'd3,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0);
        vecs[1]  = mk(0, 0, 5'd3,  2'b00, 32'h0,        32'h0,        32'h0,        5'd3,  5'd31, 5'd3,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF);
        vecs[2]  = mk(0, 1, 5'd0,  2'b01, 32'h0,        32'h12345678, 32'h0,        5'd0,  5'd0,  5'd0,  32'h12345678, 32'h0,        32'h0,        32'h0);
        vecs[3]  = mk(0, 1, 5'd1,  2'b10, 32'h0,        32'h0,        32'h00000104, 5'd1,  5'd0,  5'd1,  32'h00000104, 32'h00000104, 32'h0,        32'h0);
        vecs[4]  = mk(0, 1, 5'd2,  2'b00, 32'h7,        32'h0,        32'h0,        5'd1,  5'd2,  5'd1,  32'h7,        32'h00000104, 32'h7,        32'h00000104);
        vecs[5]  = mk(0, 1, 5'd2,  2'b11, 32'h9,        32'h9,        32'h9,        5'd2,  5'd2,  5'd2,  32'h0,        32'h0,        32'h0,        32'h7);
        vecs[6]  = mk(0, 0, 5'd0,  2'b00, 32'h0,        32'h0,        32'h0,        5'd2,  5'd0,  5'd2,  32'h0,        32'h0,        32'h0,        32'h0);
        vecs[7]  = mk(0, 1, 5'd4,  2'b00, 32'hAAAAAAAA, 32'h0,        32'h0,        5'd4,  5'd4,  5'd4,  32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h0);
        vecs[8]  = mk(1, 1, 5'd4,  2'b00, 32'h5,        32'h0,        32'h0,        5'd4,  5'd3,  5'd4,  32'h5,        32'hAAAAAAAA, 32'hDEADBEEF, 32'hAAAAAAAA);
        vecs[9]  = mk(0, 0, 5'd0,  2'b00, 32'h0,        32'h0,        32'h0,        5'd4,  5'd3,  5'd4,  32'h0,        32'h0,        32'h0,        32'h0);
        vecs[10] = mk(0, 1, 5'd7,  2'b00, 32'h1,        32'h0,        32'h0,        5'd7,  5'd7,  5'd7,  32'h1,        32'h1,        32'h1,        32'h0);
        vecs[11] = mk(0, 1, 5'd7,  2'b00, 32'h2,        32'h0,        32'h0,        5'd7,  5'd7,  5'd7,  32'h2,        32'h2,        32'h2,        32'h1);
        vecs[12] = mk(0, 0, 5'd0,  2'b00, 32'h0,        32'h0,        32'h0,        5'd7,  5'd7,  5'd7,  32'h0,        32'h2,        32'h2,        32'h2);
        vecs[13] = mk(0, 1, 5'd31, 2'b01, 32'h0,        32'hCAFEF00D, 32'h0,        5'd31, 5'd30, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0,        32'h0);
        vecs[14] = mk(0, 0, 5'd31, 2'b00, 32'h55,       32'h0,        32'h0,        5'd31, 5'd31, 5'd31, 32'h55,       32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D);

        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            drive(vecs[k].rst, vecs[k].wr, vecs[k].rd, vecs[k].src, vecs[k].alu,
                  vecs[k].mem, vecs[k].pc4, vecs[k].rs1, vecs[k].rs2, vecs[k].dbg);
            #1;
            check($sformatf("v%0d_result", k), ResultW,  vecs[k].exp_res);
            check($sformatf("v%0d_rd1", k),    RD1D,     vecs[k].exp_rd1);
            check($sformatf("v%0d_rd2", k),    RD2D,     vecs[k].exp_rd2);
            check($sformatf("v%0d_dbg", k),    dbg_data, vecs[k].exp_dbg);
        end

        // Fill every register with a distinct value, then read all back.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 5'(i), 2'b00, 32'h5A5A0000 ^ 32'(i), 32'h0, 32'h0,
                  5'd0, 5'd0, 5'd0);
        end
        @(negedge clk);
        idle();
        dbg_sweep("fill_dbg", 32'h5A5A0000, 1'b0);
        for (int i = 1; i < 32; i++) begin
            rs1D = 5'(i);
            rs2D = 5'(31 - i);
            #1;
            check($sformatf("fill_rd1[%0d]", i), RD1D, 32'h5A5A0000 ^ 32'(i));
            check($sformatf("fill_rd2[%0d]", 31 - i), RD2D,
                  (i == 31) ? 32'h0 : 32'h5A5A0000 ^ 32'(31 - i));
        end

        // Reset again clears everything that was written.
        @(negedge clk);
        drive(1'b1, 1'b1, 5'd9, 2'b00, 32'h99, 32'h0, 32'h0, 5'd9, 5'd9, 5'd9);
        #1;
        check("rst2_nobypass", RD1D, 32'h5A5A0009);
        @(negedge clk);
        idle();
        dbg_sweep("rst2_dbg", 32'h0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
